// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle between NM masters, the round-robin arbiter and one shared slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_rr_arbiter_if #(
  parameter int NM = 2
);
  logic [NM-1:0]      p_m_wb_CYC_I;
  logic [NM-1:0]      p_m_wb_STB_I;
  logic [NM-1:0]      p_m_wb_WE_I;
  logic [NM-1:0]      p_m_wb_LOCK_I;
  logic [4*NM-1:0]    p_m_wb_SEL_I;
  logic [32*NM-1:0]   p_m_wb_ADR_I;
  logic [32*NM-1:0]   p_m_wb_DAT_I;
  logic [31:0]        p_m_wb_DAT_O;
  logic [NM-1:0]      p_m_wb_ACK_O;
  logic [NM-1:0]      p_m_wb_ERR_O;
  logic [NM-1:0]      p_m_wb_RTY_O;

  logic               p_s_wb_CYC_O;
  logic               p_s_wb_STB_O;
  logic               p_s_wb_WE_O;
  logic               p_s_wb_LOCK_O;
  logic [3:0]         p_s_wb_SEL_O;
  logic [31:0]        p_s_wb_ADR_O;
  logic [31:0]        p_s_wb_DAT_O;
  logic [31:0]        p_s_wb_DAT_I;
  logic               p_s_wb_ACK_I;
  logic               p_s_wb_ERR_I;
  logic               p_s_wb_RTY_I;

  modport slave (
    input  p_m_wb_CYC_I, p_m_wb_STB_I, p_m_wb_WE_I, p_m_wb_LOCK_I,
    input  p_m_wb_SEL_I, p_m_wb_ADR_I, p_m_wb_DAT_I,
    output p_m_wb_DAT_O, p_m_wb_ACK_O, p_m_wb_ERR_O, p_m_wb_RTY_O,
    output p_s_wb_CYC_O, p_s_wb_STB_O, p_s_wb_WE_O, p_s_wb_LOCK_O,
    output p_s_wb_SEL_O, p_s_wb_ADR_O, p_s_wb_DAT_O,
    input  p_s_wb_DAT_I, p_s_wb_ACK_I, p_s_wb_ERR_I, p_s_wb_RTY_I
  );

  modport master (
    output p_m_wb_CYC_I, p_m_wb_STB_I, p_m_wb_WE_I, p_m_wb_LOCK_I,
    output p_m_wb_SEL_I, p_m_wb_ADR_I, p_m_wb_DAT_I,
    input  p_m_wb_DAT_O, p_m_wb_ACK_O, p_m_wb_ERR_O, p_m_wb_RTY_O,
    input  p_s_wb_CYC_O, p_s_wb_STB_O, p_s_wb_WE_O, p_s_wb_LOCK_O,
    input  p_s_wb_SEL_O, p_s_wb_ADR_O, p_s_wb_DAT_O,
    output p_s_wb_DAT_I, p_s_wb_ACK_I, p_s_wb_ERR_I, p_s_wb_RTY_I
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave between NM masters, with bus-lock support.
// Define WB_ARB_WATCHDOG_EN to add a stall watchdog that aborts unanswered transfers with ERR.
module wb_rr_arbiter #(
  parameter int NM      = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  p_clk,
  input  logic                  p_resetn,
  wb_rr_arbiter_if.slave        bus,
  output logic [$clog2(NM)-1:0] p_grant,
  output logic                  p_grant_valid
);
  localparam int GW = $clog2(NM);

  if (NM < 2 || NM > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("wb_rr_arbiter: NM must be 2..8 and TIMEOUT at least 1");
  end

`ifdef WB_ARB_WATCHDOG_EN
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] stall_cnt, stall_cnt_nx;
`else
  typedef enum logic {IDLE, BUSY} state_t;
`endif

  state_t        state, state_nx;
  logic [GW-1:0] last, last_nx, grant_nx, pick, idx;
  logic          found;
  logic          cyc_g, stb_g, lock_g, resp;
  logic [3:0]    sel_a [NM];
  logic [31:0]   adr_a [NM];
  logic [31:0]   dat_a [NM];

  for (genvar i = 0; i < NM; i++) begin : g_unpack
    assign sel_a[i] = bus.p_m_wb_SEL_I[4*i +: 4];
    assign adr_a[i] = bus.p_m_wb_ADR_I[32*i +: 32];
    assign dat_a[i] = bus.p_m_wb_DAT_I[32*i +: 32];
  end

  assign cyc_g         = bus.p_m_wb_CYC_I[p_grant];
  assign stb_g         = bus.p_m_wb_STB_I[p_grant];
  assign lock_g        = bus.p_m_wb_LOCK_I[p_grant];
  assign resp          = bus.p_s_wb_ACK_I | bus.p_s_wb_ERR_I | bus.p_s_wb_RTY_I;
  assign p_grant_valid = (state != IDLE);

  // Scan starts just after the previous owner so every requester is reached within NM turns.
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NM; i++) begin
      idx = GW'((int'(last) + i) % NM);
      if (!found && bus.p_m_wb_CYC_I[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state   <= IDLE;
      p_grant <= '0;
      last    <= GW'(NM - 1);
`ifdef WB_ARB_WATCHDOG_EN
      stall_cnt <= '0;
`endif
    end else begin
      state   <= state_nx;
      p_grant <= grant_nx;
      last    <= last_nx;
`ifdef WB_ARB_WATCHDOG_EN
      stall_cnt <= stall_cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = p_grant;
    last_nx  = last;
`ifdef WB_ARB_WATCHDOG_EN
    stall_cnt_nx = '0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = pick;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        // A locked owner keeps the slave even while its CYC is low.
        if (!cyc_g && !lock_g) begin
          last_nx  = p_grant;
          state_nx = IDLE;
        end
`ifdef WB_ARB_WATCHDOG_EN
        else if (stb_g && !resp) begin
          if (stall_cnt + 1'b1 == CW'(TIMEOUT)) state_nx = ABORT;
          else stall_cnt_nx = stall_cnt + 1'b1;
        end
      end
      ABORT: begin
        last_nx  = p_grant;
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.p_s_wb_CYC_O  = 1'b0;
    bus.p_s_wb_STB_O  = 1'b0;
    bus.p_s_wb_WE_O   = 1'b0;
    bus.p_s_wb_LOCK_O = 1'b0;
    bus.p_s_wb_SEL_O  = '0;
    bus.p_s_wb_ADR_O  = '0;
    bus.p_s_wb_DAT_O  = '0;
    bus.p_m_wb_DAT_O  = '0;
    bus.p_m_wb_ACK_O  = '0;
    bus.p_m_wb_ERR_O  = '0;
    bus.p_m_wb_RTY_O  = '0;
    if (state == BUSY) begin
      bus.p_s_wb_CYC_O          = cyc_g;
      bus.p_s_wb_STB_O          = stb_g;
      bus.p_s_wb_WE_O           = bus.p_m_wb_WE_I[p_grant];
      bus.p_s_wb_LOCK_O         = lock_g;
      bus.p_s_wb_SEL_O          = sel_a[p_grant];
      bus.p_s_wb_ADR_O          = adr_a[p_grant];
      bus.p_s_wb_DAT_O          = dat_a[p_grant];
      bus.p_m_wb_DAT_O          = bus.p_s_wb_DAT_I;
      bus.p_m_wb_ACK_O[p_grant] = bus.p_s_wb_ACK_I;
      bus.p_m_wb_ERR_O[p_grant] = bus.p_s_wb_ERR_I;
      bus.p_m_wb_RTY_O[p_grant] = bus.p_s_wb_RTY_I;
    end
`ifdef WB_ARB_WATCHDOG_EN
    else if (state == ABORT) begin
      bus.p_m_wb_ERR_O[p_grant] = 1'b1;
    end
`endif
  end
endmodule
